// File: rtl/axistream_strip_tlast_if.sv
// Stream bundle for the tlast stripper: framed source in, unframed data out, length out.
// The slave modport is the stripper's view; master is the surrounding logic's view.
interface axistream_strip_tlast_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) ();
  logic                   src_tvalid;
  logic                   src_tready;
  logic [DATA_WIDTH-1:0]  src_tdata;
  logic                   src_tlast;
  logic                   dest_tvalid;
  logic                   dest_tready;
  logic [DATA_WIDTH-1:0]  dest_tdata;
  logic                   len_tvalid;
  logic                   len_tready;
  logic [COUNT_WIDTH-1:0] len_tdata;

  modport slave (
    input  src_tvalid, src_tdata, src_tlast, dest_tready, len_tready,
    output src_tready, dest_tvalid, dest_tdata, len_tvalid, len_tdata
  );

  modport master (
    output src_tvalid, src_tdata, src_tlast, dest_tready, len_tready,
    input  src_tready, dest_tvalid, dest_tdata, len_tvalid, len_tdata
  );
endinterface

// File: rtl/axistream_strip_tlast.sv
// Strips tlast from an AXI stream and reports per-packet word counts; data and length each 1-cycle registered.
// Backpressure: src stalls when the data register is held, or on a last word while an unconsumed length is held.
module axistream_strip_tlast #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axistream_strip_tlast_if.slave   bus,
  output logic                     len_overflow
);

  logic                   data_free;
  logic                   len_free;
  logic                   src_rdy;
  logic                   accept;
  logic                   dbuf_vld;
  logic [DATA_WIDTH-1:0]  dbuf_dat;
  logic                   len_vld;
  logic [COUNT_WIDTH-1:0] len_dat;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic                   cnt_at_max;

  assign data_free = !dbuf_vld || bus.dest_tready;
  assign len_free  = !len_vld || bus.len_tready;

  // Only a last word needs room in the length register; rst_n gates ready so reset drops it at once.
  assign src_rdy = rst_n && data_free && (!bus.src_tlast || len_free);
  assign accept  = bus.src_tvalid && src_rdy;

  assign cnt_at_max = &cnt;
  assign cnt_inc    = cnt_at_max ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbuf_vld <= 1'b0;
      dbuf_dat <= '0;
    end else if (accept) begin
      dbuf_vld <= 1'b1;
      dbuf_dat <= bus.src_tdata;
    end else if (bus.dest_tready) begin
      dbuf_vld <= 1'b0;
      dbuf_dat <= '0;
    end
  end

  // A fresh last word takes priority over the drain so the length reloads without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_vld <= 1'b0;
      len_dat <= '0;
    end else if (accept && bus.src_tlast) begin
      len_vld <= 1'b1;
      len_dat <= cnt_inc;
    end else if (bus.len_tready) begin
      len_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      len_overflow <= 1'b0;
    end else if (accept) begin
      cnt <= bus.src_tlast ? '0 : cnt_inc;
      if (cnt_at_max) begin
        len_overflow <= 1'b1;
      end
    end
  end

  assign bus.src_tready  = src_rdy;
  assign bus.dest_tvalid = dbuf_vld;
  assign bus.dest_tdata  = dbuf_dat;
  assign bus.len_tvalid  = len_vld;
  assign bus.len_tdata   = len_dat;

endmodule

// File: tb/tb_axistream_strip_tlast.sv
// Directed bench: wide-counter instance for framing/backpressure/reset cases, 3-bit-counter instance for saturation.
module tb_axistream_strip_tlast;

  logic clk = 1'b0;
  logic rst_n;
  logic a_ovf;
  logic b_ovf;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  axistream_strip_tlast_if #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) a_if ();
  axistream_strip_tlast_if #(.DATA_WIDTH(8), .COUNT_WIDTH(3))  b_if ();

  axistream_strip_tlast #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (a_if.slave),
    .len_overflow (a_ovf)
  );

  axistream_strip_tlast #(.DATA_WIDTH(8), .COUNT_WIDTH(3)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (b_if.slave),
    .len_overflow (b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] d, input logic l);
    a_if.src_tvalid = v;
    a_if.src_tdata  = d;
    a_if.src_tlast  = l;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] d, input logic l);
    b_if.src_tvalid = v;
    b_if.src_tdata  = d;
    b_if.src_tlast  = l;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_src_tready"},  32'(a_if.src_tready),  32'h0);
    chk({tag, "_dest_tvalid"}, 32'(a_if.dest_tvalid), 32'h0);
    chk({tag, "_dest_tdata"},  32'(a_if.dest_tdata),  32'h0);
    chk({tag, "_len_tvalid"},  32'(a_if.len_tvalid),  32'h0);
    chk({tag, "_len_tdata"},   32'(a_if.len_tdata),   32'h0);
    chk({tag, "_len_overflow"}, 32'(a_ovf),           32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive_a(1'b0, 8'h00, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0);
    a_if.dest_tready = 1'b1;
    a_if.len_tready  = 1'b1;
    b_if.dest_tready = 1'b1;
    b_if.len_tready  = 1'b1;
    #2;
    chk_a_zero("reset");
    chk("reset_b_ovf", 32'(b_ovf), 32'h0);
    #20;
    rst_n = 1'b1;
    step();

    // 1: three-word packet at full throughput
    drive_a(1'b1, 8'h11, 1'b0);
    #1 chk("t1_rdy0", 32'(a_if.src_tready), 32'h1);
    step();
    chk("t1_v11", 32'(a_if.dest_tvalid), 32'h1);
    chk("t1_d11", 32'(a_if.dest_tdata), 32'h11);
    chk("t1_lv11", 32'(a_if.len_tvalid), 32'h0);
    drive_a(1'b1, 8'h22, 1'b0);
    step();
    chk("t1_d22", 32'(a_if.dest_tdata), 32'h22);
    drive_a(1'b1, 8'h33, 1'b1);
    #1 chk("t1_rdy_last", 32'(a_if.src_tready), 32'h1);
    step();
    chk("t1_d33", 32'(a_if.dest_tdata), 32'h33);
    chk("t1_lv", 32'(a_if.len_tvalid), 32'h1);
    chk("t1_len", 32'(a_if.len_tdata), 32'h3);
    drive_a(1'b0, 8'h00, 1'b0);
    step();
    chk("t1_dv_clr", 32'(a_if.dest_tvalid), 32'h0);
    chk("t1_dd_clr", 32'(a_if.dest_tdata), 32'h0);
    chk("t1_lv_clr", 32'(a_if.len_tvalid), 32'h0);
    chk("t1_ovf", 32'(a_ovf), 32'h0);

    // 2: back-to-back one-word packets with the length consumer stalled
    a_if.len_tready = 1'b0;
    drive_a(1'b1, 8'hA0, 1'b1);
    step();
    chk("t2_dA0", 32'(a_if.dest_tdata), 32'hA0);
    chk("t2_lv0", 32'(a_if.len_tvalid), 32'h1);
    chk("t2_len0", 32'(a_if.len_tdata), 32'h1);
    drive_a(1'b1, 8'hA1, 1'b1);
    #1 chk("t2_blocked", 32'(a_if.src_tready), 32'h0);
    step();
    chk("t2_dv_drained", 32'(a_if.dest_tvalid), 32'h0);
    chk("t2_len_held", 32'(a_if.len_tdata), 32'h1);
    chk("t2_blocked2", 32'(a_if.src_tready), 32'h0);
    a_if.len_tready = 1'b1;
    #1 chk("t2_unblocked", 32'(a_if.src_tready), 32'h1);
    step();
    a_if.len_tready = 1'b0;
    chk("t2_dA1", 32'(a_if.dest_tdata), 32'hA1);
    chk("t2_lv1", 32'(a_if.len_tvalid), 32'h1);
    chk("t2_len1", 32'(a_if.len_tdata), 32'h1);
    drive_a(1'b0, 8'h00, 1'b0);
    step();
    chk("t2_len_hold", 32'(a_if.len_tvalid), 32'h1);
    a_if.len_tready = 1'b1;
    step();
    chk("t2_lv_clr", 32'(a_if.len_tvalid), 32'h0);

    // 3: six-word packet with a four-cycle downstream stall
    drive_a(1'b1, 8'h01, 1'b0);
    step();
    chk("t3_d01", 32'(a_if.dest_tdata), 32'h01);
    drive_a(1'b1, 8'h02, 1'b0);
    step();
    chk("t3_d02", 32'(a_if.dest_tdata), 32'h02);
    drive_a(1'b1, 8'h03, 1'b0);
    a_if.dest_tready = 1'b0;
    #1 chk("t3_rdy_drop", 32'(a_if.src_tready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold_v", 32'(a_if.dest_tvalid), 32'h1);
      chk("t3_hold_d", 32'(a_if.dest_tdata), 32'h02);
    end
    a_if.dest_tready = 1'b1;
    #1 chk("t3_rdy_back", 32'(a_if.src_tready), 32'h1);
    step();
    chk("t3_d03", 32'(a_if.dest_tdata), 32'h03);
    for (int i = 4; i <= 6; i++) begin
      drive_a(1'b1, 8'(i), i == 6);
      step();
      chk("t3_dn", 32'(a_if.dest_tdata), 32'(i));
      chk("t3_lv", 32'(a_if.len_tvalid), 32'(i == 6));
    end
    chk("t3_len", 32'(a_if.len_tdata), 32'h6);
    drive_a(1'b0, 8'h00, 1'b0);
    step();

    // 6: length reload on the same edge it is consumed
    a_if.len_tready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive_a(1'b1, 8'(8'h70 + i), i == 5);
      step();
    end
    chk("t6_lv5", 32'(a_if.len_tvalid), 32'h1);
    chk("t6_len5", 32'(a_if.len_tdata), 32'h5);
    drive_a(1'b1, 8'h81, 1'b0);
    #1 chk("t6_nonlast_rdy", 32'(a_if.src_tready), 32'h1);
    step();
    chk("t6_d81", 32'(a_if.dest_tdata), 32'h81);
    chk("t6_len5_held", 32'(a_if.len_tdata), 32'h5);
    drive_a(1'b1, 8'h82, 1'b1);
    a_if.len_tready = 1'b1;
    #1 chk("t6_last_rdy", 32'(a_if.src_tready), 32'h1);
    step();
    chk("t6_d82", 32'(a_if.dest_tdata), 32'h82);
    chk("t6_lv_reload", 32'(a_if.len_tvalid), 32'h1);
    chk("t6_len2", 32'(a_if.len_tdata), 32'h2);
    drive_a(1'b0, 8'h00, 1'b0);
    step();
    chk("t6_lv_clr", 32'(a_if.len_tvalid), 32'h0);

    // 4: saturation on the 3-bit counter instance
    for (int k = 1; k <= 9; k++) begin
      drive_b(1'b1, 8'(8'h90 + k), k == 9);
      step();
      chk("t4_dat", 32'(b_if.dest_tdata), 32'(8'h90 + k));
      chk("t4_ovf", 32'(b_ovf), 32'(k >= 8));
    end
    chk("t4_lv7", 32'(b_if.len_tvalid), 32'h1);
    chk("t4_len7", 32'(b_if.len_tdata), 32'h7);
    drive_b(1'b1, 8'hB1, 1'b0);
    step();
    drive_b(1'b1, 8'hB2, 1'b1);
    step();
    chk("t4_lv2", 32'(b_if.len_tvalid), 32'h1);
    chk("t4_len2", 32'(b_if.len_tdata), 32'h2);
    chk("t4_ovf_sticky", 32'(b_ovf), 32'h1);
    drive_b(1'b0, 8'h00, 1'b0);
    step();

    // 5: asynchronous reset mid-packet
    drive_a(1'b1, 8'h51, 1'b0);
    step();
    drive_a(1'b1, 8'h52, 1'b0);
    step();
    chk("t5_pre_v", 32'(a_if.dest_tvalid), 32'h1);
    drive_a(1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_a_zero("t5_async");
    chk("t5_b_ovf_clr", 32'(b_ovf), 32'h0);
    #3 rst_n = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      drive_a(1'b1, 8'(8'h60 + i), i == 4);
      step();
    end
    chk("t5_d64", 32'(a_if.dest_tdata), 32'h64);
    chk("t5_lv", 32'(a_if.len_tvalid), 32'h1);
    chk("t5_len4", 32'(a_if.len_tdata), 32'h4);
    drive_a(1'b0, 8'h00, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
